// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between two requesters, one message at a time.
// Latency: valid sampled in IDLE at k -> ack/tx_data at k+1 -> ready pulse at k+2.
// Backpressure: requesters hold valid until their one-cycle ack; arbitration waits for tdre.
module uart_tx_arbiter #(
    parameter int BUSY_TIMEOUT = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0_valid,
    input  logic [7:0]       req0_data,
    input  logic             req0_last,
    output logic             req0_ack,
    input  logic             req1_valid,
    input  logic [7:0]       req1_data,
    input  logic             req1_last,
    output logic             req1_ack,
    input  logic             tdre,
    output logic [7:0]       tx_data,
    output logic             ready,
    output logic             busy,
    output logic             owner,
    output logic             locked,
    output logic             err,
    input  logic             err_clear,
    output logic [CNT_W-1:0] bytes_sent
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIRE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    // Timer counts WAIT_BUSY cycles; the last allowed cycle triggers the timeout.
    localparam logic [3:0] TMO_LAST = 4'(BUSY_TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] timer;
    logic       last_q;   // last flag of the byte in flight
    logic       rr_last;  // owner of the most recently completed message
    logic       grant;
    logic       sel;
    logic       fall;
    logic       timeout;
    logic       done;

    // Next-state and event decode; arbitration only while the transmitter is idle.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        sel       = owner;
        fall      = 1'b0;
        timeout   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (tdre) begin
                    if (locked) begin
                        sel   = owner;
                        grant = owner ? req1_valid : req0_valid;
                    end else if (req0_valid && req1_valid) begin
                        sel   = ~rr_last;
                        grant = 1'b1;
                    end else if (req0_valid || req1_valid) begin
                        sel   = req1_valid;
                        grant = 1'b1;
                    end
                    if (grant) begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD:      state_nxt = FIRE;
            FIRE:      state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!tdre) begin
                    fall      = 1'b1;
                    state_nxt = WAIT_DONE;
                end else if (timer == TMO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (tdre) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default:   state_nxt = IDLE;
        endcase
    end

    // State register and all registered outputs; a timeout overrides err_clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            timer      <= '0;
            last_q     <= 1'b0;
            rr_last    <= 1'b1;
            tx_data    <= '0;
            ready      <= 1'b0;
            req0_ack   <= 1'b0;
            req1_ack   <= 1'b0;
            busy       <= 1'b0;
            owner      <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            bytes_sent <= '0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != IDLE);
            ready    <= (state == LOAD);
            req0_ack <= grant && !sel;
            req1_ack <= grant && sel;
            if (grant) begin
                tx_data <= sel ? req1_data : req0_data;
                last_q  <= sel ? req1_last : req0_last;
                owner   <= sel;
            end
            if (state == FIRE) begin
                timer <= '0;
            end else if (state == WAIT_BUSY) begin
                timer <= timer + 4'd1;
            end
            if (fall) begin
                bytes_sent <= bytes_sent + CNT_W'(1);
            end
            if (err_clear) begin
                err <= 1'b0;
            end
            if (timeout) begin
                err    <= 1'b1;
                locked <= 1'b0;
            end
            if (done) begin
                if (last_q) begin
                    locked  <= 1'b0;
                    rr_last <= owner;
                end else begin
                    locked <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed steps plus random message batches.
// Expected transmit order comes from a message-level round-robin model.
// A uart_tx model answers each ready pulse with a random tdre low pulse.
module tb_uart_tx_arbiter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        req0_valid, req0_last, req0_ack;
    logic        req1_valid, req1_last, req1_ack;
    logic [7:0]  req0_data, req1_data, tx_data;
    logic        tdre, ready, busy, owner, locked, err;
    logic        err_clear = 1'b0;
    logic [15:0] bytes_sent;
    logic        w_req0_ack, w_req1_ack, w_ready, w_busy, w_owner, w_locked, w_err;
    logic [7:0]  w_tx_data;
    logic [3:0]  w_bytes_sent;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] q0[$], q1[$];   // driver queues {last, data}
    logic [8:0] p0[$], p1[$];   // messages of the current batch, for the model
    logic [8:0] txq[$];         // observed {owner, tx_data} at each ready pulse
    bit stuck = 1'b0;
    bit hold_long = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.BUSY_TIMEOUT(T), .CNT_W(16)) dut (
        .clk(clk), .clr(clr),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ack(req0_ack),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ack(req1_ack),
        .tdre(tdre), .tx_data(tx_data), .ready(ready), .busy(busy), .owner(owner),
        .locked(locked), .err(err), .err_clear(err_clear), .bytes_sent(bytes_sent)
    );

    // Narrow-counter instance sharing all inputs, used to observe wrap-around.
    uart_tx_arbiter #(.BUSY_TIMEOUT(T), .CNT_W(4)) dut_w (
        .clk(clk), .clr(clr),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ack(w_req0_ack),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ack(w_req1_ack),
        .tdre(tdre), .tx_data(w_tx_data), .ready(w_ready), .busy(w_busy), .owner(w_owner),
        .locked(w_locked), .err(w_err), .err_clear(err_clear), .bytes_sent(w_bytes_sent)
    );

    // Requester drivers: present queue heads, pop on ack (sampled just after the edge).
    initial begin
        logic [8:0] h;
        req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (req0_ack && q0.size() > 0) void'(q0.pop_front());
            if (req1_ack && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0) begin
                h = q0[0];
                req0_valid = 1'b1; req0_data = h[7:0]; req0_last = h[8];
            end else begin
                req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
            end
            if (q1.size() > 0) begin
                h = q1[0];
                req1_valid = 1'b1; req1_data = h[7:0]; req1_last = h[8];
            end else begin
                req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
            end
        end
    end

    // uart_tx model: records each started byte, then drops tdre for a while.
    initial begin
        tdre = 1'b1;
        forever begin
            @(negedge clk);
            if (ready === 1'b1) begin
                txq.push_back({owner, tx_data});
                if (!stuck) begin
                    repeat ($urandom_range(1, 2)) @(negedge clk);
                    tdre = 1'b0;
                    repeat (hold_long ? 30 : $urandom_range(1, 4)) @(negedge clk);
                    tdre = 1'b1;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        q0.delete(); q1.delete(); p0.delete(); p1.delete(); txq.delete();
        repeat (2) @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_ack0"}, req0_ack, 0);
        chk({tag, "_ack1"}, req1_ack, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_owner"}, owner, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_bytes"}, bytes_sent, 0);
    endtask

    task automatic wait_drain(string tag);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain_in_time"}, (n < 3000), 1);
    endtask

    task automatic wait_ready(string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_in_time"}, (n < 200), 1);
    endtask

    // Model: whole messages alternate between requesters when both have one pending;
    // requester 0 wins the first tie after reset.
    task automatic run_batch(string tag);
        logic [8:0] e[$];
        logic [8:0] w;
        int i0 = 0;
        int i1 = 0;
        bit lo = 1'b1;
        bit pick;
        while (i0 < p0.size() || i1 < p1.size()) begin
            if (i0 < p0.size() && i1 < p1.size()) pick = !lo;
            else pick = (i0 >= p0.size());
            do begin
                if (!pick) begin w = p0[i0]; i0++; end
                else begin w = p1[i1]; i1++; end
                e.push_back({pick, w[7:0]});
            end while (!w[8] && (pick ? (i1 < p1.size()) : (i0 < p0.size())));
            lo = pick;
        end
        txq.delete();
        q0 = p0;
        q1 = p1;
        wait_drain(tag);
        chk({tag, "_count"}, txq.size(), e.size());
        for (int k = 0; k < e.size() && k < txq.size(); k++)
            chk($sformatf("%s_byte%0d", tag, k), txq[k], e[k]);
        chk({tag, "_bytes_sent"}, bytes_sent, e.size());
        chk({tag, "_bytes_sent_w4"}, w_bytes_sent, e.size() % 16);
        chk({tag, "_locked_end"}, locked, 0);
        chk({tag, "_owner_end"}, owner, lo);
        p0.delete();
        p1.delete();
    endtask

    initial begin
        int bs;
        int nm;
        int len;
        // Reset values
        do_reset();
        chk_reset("rst");

        // Single byte latency
        q0.push_back({1'b1, 8'h55});
        @(negedge clk);
        chk("lat_valid_k", req0_valid, 1);
        @(negedge clk);
        chk("lat_ack_k1", req0_ack, 1);
        chk("lat_txd_k1", tx_data, 8'h55);
        chk("lat_ready_k1", ready, 0);
        chk("lat_owner_k1", owner, 0);
        @(negedge clk);
        chk("lat_ready_k2", ready, 1);
        chk("lat_ack_k2", req0_ack, 0);
        @(negedge clk);
        chk("lat_ready_k3", ready, 0);
        wait_drain("lat");
        chk("lat_bytes", bytes_sent, 1);
        chk("lat_locked", locked, 0);

        // Timeout with tdre stuck high
        stuck = 1'b1;
        bs = bytes_sent;
        q0.push_back({1'b1, 8'h77});
        wait_ready("tmo");
        repeat (T) @(negedge clk);
        chk("tmo_err_before", err, 0);
        chk("tmo_busy_before", busy, 1);
        @(negedge clk);
        chk("tmo_err", err, 1);
        chk("tmo_idle", busy, 0);
        chk("tmo_bytes", bytes_sent, bs);
        chk("tmo_locked", locked, 0);
        err_clear = 1'b1;
        @(negedge clk);
        chk("tmo_err_cleared", err, 0);
        // Timeout coinciding with err_clear still sets err
        q0.push_back({1'b1, 8'h78});
        wait_ready("tmo2");
        repeat (T) @(negedge clk);
        chk("tmo2_err_before", err, 0);
        @(negedge clk);
        chk("tmo2_err_wins", err, 1);
        err_clear = 1'b0;
        @(negedge clk);
        chk("tmo2_err_sticky", err, 1);
        err_clear = 1'b1;
        @(negedge clk);
        chk("tmo2_err_cleared", err, 0);
        err_clear = 1'b0;
        stuck = 1'b0;

        // Message lock: req1 waits behind a two-byte message
        do_reset();
        p0.push_back({1'b0, 8'hA1}); p0.push_back({1'b1, 8'hA2});
        p1.push_back({1'b1, 8'h3C});
        run_batch("lock");

        // Round-robin between single-byte messages
        do_reset();
        p0.push_back({1'b1, 8'h11}); p0.push_back({1'b1, 8'h11});
        p1.push_back({1'b1, 8'h22}); p1.push_back({1'b1, 8'h22});
        run_batch("rr");

        // Reset during WAIT_DONE of a locked message
        do_reset();
        hold_long = 1'b1;
        q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b0, 8'hA2}); q0.push_back({1'b1, 8'hA3});
        q1.push_back({1'b1, 8'h3C});
        begin
            int n = 0;
            while (!(locked === 1'b1 && busy === 1'b1 && bytes_sent == 16'd2) && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk("mid_reach_wait_done", (n < 500), 1);
        end
        clr = 1'b1;
        q0.delete();
        txq.delete();
        @(negedge clk);
        chk_reset("mid_rst");
        clr = 1'b0;
        hold_long = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_no_grant_tdre_low", busy, 0);
        chk("mid_no_ack_tdre_low", req1_ack, 0);
        wait_drain("mid");
        chk("mid_count", txq.size(), 1);
        if (txq.size() > 0) chk("mid_byte", txq[0], {1'b1, 8'h3C});
        chk("mid_bytes", bytes_sent, 1);
        chk("mid_owner", owner, 1);

        // Counter wrap on the 4-bit instance
        do_reset();
        for (int k = 0; k < 16; k++) p0.push_back({1'b1, 8'(k * 7)});
        run_batch("wrap");
        chk("wrap_zero_w4", w_bytes_sent, 0);

        // Random message batches
        for (int b = 0; b < 4; b++) begin
            do_reset();
            for (int r = 0; r < 2; r++) begin
                nm = $urandom_range(1, 4);
                for (int m = 0; m < nm; m++) begin
                    len = $urandom_range(1, 3);
                    for (int j = 0; j < len; j++) begin
                        if (r == 0) p0.push_back({(j == len - 1), 8'($urandom)});
                        else p1.push_back({(j == len - 1), 8'($urandom)});
                    end
                end
            end
            run_batch($sformatf("rnd%0d", b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
